// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 1024x768 timing constants and derived line/frame totals
package vga_timing_pkg;
    localparam int H_VISIBLE = 1024;
    localparam int H_FRONT   = 24;
    localparam int H_SYNC    = 136;
    localparam int H_BACK    = 160;
    localparam int V_VISIBLE = 768;
    localparam int V_FRONT   = 3;
    localparam int V_SYNC    = 6;
    localparam int V_BACK    = 29;

    function automatic int total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    localparam int H_TOTAL = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
endpackage

// File: rtl/sweep_counter.sv
// sweep_counter: modulo-N counter with enable, exposing its next value and a wrap strobe
module sweep_counter #(
    parameter int N = 1344,
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] next,
    output logic         wrap
);
    logic at_max;

    always_comb begin
        at_max = count == W'(N - 1);
        wrap   = en && at_max;
        next   = en ? (at_max ? '0 : count + W'(1)) : count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else       count <= next;
    end
endmodule

// File: rtl/beam_sweep_generator.sv
// beam_sweep_generator: raster beam position and sync decode; BEAM_FRAME_TICK_EN adds frame_start/frame_count
module beam_sweep_generator #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic [10:0] beam_x,
    output logic [9:0]  beam_y,
    output logic        draw,
    output logic        hsync,
    output logic        vsync
`ifdef BEAM_FRAME_TICK_EN
    ,
    output logic        frame_start,
    output logic [15:0] frame_count
`endif
);
    localparam int H_TOTAL = vga_timing_pkg::total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = vga_timing_pkg::total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam logic [10:0] X_VIS = 11'(H_VISIBLE);
    localparam logic [10:0] HS_LO = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_HI = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  Y_VIS = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_LO = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] nx;
    logic [9:0]  ny;
    logic        x_wrap;
    logic        frame_wrap;

    sweep_counter #(.N(H_TOTAL), .W(11)) u_x (
        .clk(clk), .reset(reset), .en(pix_en),
        .count(beam_x), .next(nx), .wrap(x_wrap)
    );

    sweep_counter #(.N(V_TOTAL), .W(10)) u_y (
        .clk(clk), .reset(reset), .en(x_wrap),
        .count(beam_y), .next(ny), .wrap(frame_wrap)
    );

    // Decoding the next position keeps flags coherent with the registered beam
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            draw  <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            draw  <= nx < X_VIS && ny < Y_VIS;
            hsync <= !(nx >= HS_LO && nx < HS_HI);
            vsync <= !(ny >= VS_LO && ny < VS_HI);
        end
    end

`ifdef BEAM_FRAME_TICK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else if (pix_en) begin
            frame_start <= frame_wrap;
            frame_count <= frame_count + 16'(frame_wrap);
        end
    end
`else
    logic unused_frame_wrap;
    assign unused_frame_wrap = frame_wrap;
`endif
endmodule

// File: doc/beam_sweep_generator.md
BEAM_SWEEP_GENERATOR -- requirements
Module: beam_sweep_generator

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 24, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 136, hsync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 160, horizontal back porch in pixels; line total is 1344.
REQ-005 SHALL have parameter V_VISIBLE, default 768, visible lines per frame.
REQ-006 SHALL have parameters V_FRONT, V_SYNC and V_BACK, defaults 3, 6 and 29 lines; frame total is 806.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port pix_en, input, 1 bit, pixel-rate enable; the beam advances only when it is high.
REQ-010 SHALL have port beam_x, output, 11 bits, current horizontal position 0..1343.
REQ-011 SHALL have port beam_y, output, 10 bits, current vertical position 0..805.
REQ-012 SHALL have port draw, output, 1 bit, high while (beam_x, beam_y) lies in the visible area.
REQ-013 SHALL have ports hsync and vsync, outputs, 1 bit each, active-low sync pulses.

Function
REQ-014 SHALL register beam_x, beam_y, draw, hsync and vsync, all updated on the same clk edge, so they are always mutually coherent.
REQ-015 SHALL hold all outputs unchanged on cycles where pix_en is low.
REQ-016 SHALL, on a pix_en cycle, increment beam_x, and wrap it from 1343 to 0.
REQ-017 SHALL increment beam_y only on the beam_x wrap, and wrap it from 805 to 0 when beam_x also wraps (simultaneous wrap gives (0,0)).
REQ-018 SHALL set draw to 1 exactly when the new beam_x < H_VISIBLE and the new beam_y < V_VISIBLE.
REQ-019 SHALL drive hsync to 0 exactly when the new beam_x is in [1048, 1183], i.e. H_VISIBLE+H_FRONT .. +H_SYNC-1.
REQ-020 SHALL drive vsync to 0 exactly when the new beam_y is in [771, 776], for the whole of each such line.
REQ-021 SHALL never produce beam_x > 1343 or beam_y > 805.
REQ-022 SHALL decode draw, hsync and vsync from the next counter values, so decode latency relative to position is zero.

Reset
REQ-023 SHALL, while reset is high, force beam_x=0, beam_y=0, draw=0, hsync=1 and vsync=1, regardless of clk.
REQ-024 SHALL, on the first pix_en edge after reset release, move to (1,0) with draw=1; pixel (0,0) of the first frame is dark by design.
REQ-025 SHALL abandon any partial line or frame when reset is asserted mid-frame, with no resumption.

Configuration
REQ-026 SHALL, when macro BEAM_FRAME_TICK_EN is defined, add output frame_start (1 bit) and output frame_count (16 bits).
REQ-027 SHALL, with BEAM_FRAME_TICK_EN defined, pulse frame_start for exactly one pix_en cycle coincident with the wrap to (0,0).
REQ-028 SHALL, with BEAM_FRAME_TICK_EN defined, increment frame_count on that same edge, wrapping 65535 to 0; both outputs reset to 0.
REQ-029 SHALL, without BEAM_FRAME_TICK_EN, omit both ports and their logic entirely.

Structure
REQ-030 SHALL take the default timing constants, and the derived H_TOTAL and V_TOTAL, from shared package vga_timing_pkg.
REQ-031 SHALL implement each axis with sub-module sweep_counter, a modulo-N counter with enable and wrap output, instantiated twice.

Verification
REQ-032 Reset held for 5 clk, then released with pix_en=1 -> (1,0), draw=1, hsync=1, vsync=1 on the first edge.
REQ-033 From (1023,0) with pix_en=1 -> next (1024,0) with draw=0; hsync falls at x=1048 and rises at x=1184.
REQ-034 From (1343,805) -> next (0,0) with draw=1; with BEAM_FRAME_TICK_EN, frame_start=1 and frame_count increments by 1.
REQ-035 With pix_en toggling 1,0,1 -> outputs frozen on the 0 cycle; a full frame takes exactly 1,083,264 pix_en cycles.
REQ-036 Count sync lines over one frame -> vsync low for exactly 6 lines (y=771..776); hsync low for exactly 136 pixels on every line.
REQ-037 Reset asserted at (500,400) -> immediate (0,0) with draw=0; frame_count=0 if compiled in.
